// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - byte-to-bit scheduler and saturating hit accountant for the 11011 detector
// Optional build macro: SEQ_DET_SCHED_LSB_FIRST_EN (serialize LSB-first instead of MSB-first).
module seq_det_sched #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              det_bit,
    output logic              det_valid,
    output logic              det_clr,
    input  logic              det_hit,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              sw_clear,
    input  logic              irq_clr,
    output logic [CNT_W-1:0]  match_count,
    output logic              irq,
    output logic              busy
);

    localparam int               BCW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0]   LAST_IDX = BCW'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [BCW-1:0]    bit_cnt;
    logic [BCW-1:0]    bit_cnt_nxt;
    logic              accept;
    logic              hit;
    logic              can_inc;
    logic [CNT_W-1:0]  count_nxt;
    logic              irq_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            match_count <= '0;
            irq         <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            match_count <= count_nxt;
            irq         <= irq_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        in_ready    = 1'b0;
        det_valid   = 1'b0;
        det_bit     = 1'b0;
        busy        = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                det_valid = 1'b1;
                busy      = 1'b1;
`ifdef SEQ_DET_SCHED_LSB_FIRST_EN
                det_bit   = shreg[0];
`else
                det_bit   = shreg[DATA_W-1];
`endif
                // Last bit opens the input so the next word follows without a bubble.
                in_ready  = (bit_cnt == '0);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase

        if (rst || sw_clear) begin
            in_ready = 1'b0;
        end
        accept = in_valid && in_ready;

        if (state == SHIFT) begin
`ifdef SEQ_DET_SCHED_LSB_FIRST_EN
            shreg_nxt   = shreg >> 1;
`else
            shreg_nxt   = shreg << 1;
`endif
            bit_cnt_nxt = bit_cnt - 1'b1;
            if (bit_cnt == '0) begin
                state_nxt = IDLE;
            end
        end

        if (accept) begin
            shreg_nxt   = in_data;
            bit_cnt_nxt = LAST_IDX;
            state_nxt   = SHIFT;
        end

        if (sw_clear) begin
            state_nxt   = IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
        end
    end

    // A hit only counts on a real bit; irq fires only when the count actually moves onto thresh.
    always_comb begin
        hit       = det_valid && det_hit && !sw_clear;
        can_inc   = hit && (match_count != CNT_MAX);
        count_nxt = match_count;
        irq_nxt   = irq;
        if (sw_clear) begin
            count_nxt = '0;
            irq_nxt   = 1'b0;
        end else begin
            if (can_inc) begin
                count_nxt = match_count + 1'b1;
            end
            if (can_inc && (thresh != '0) && (count_nxt == thresh)) begin
                irq_nxt = 1'b1;
            end else if (irq_clr) begin
                irq_nxt = 1'b0;
            end
        end
    end

    assign det_clr = rst | sw_clear;

endmodule
